// File: rtl/ymc_ctrl.sv
// Multi-cycle control FSM for the y-series MIPS datapath: issues one datapath
// phase per cycle and tracks interrupts, illegal opcodes and retired instructions.
module ymc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             irq,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             branch,
  output logic             jump,
  output logic             INT,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    VEC    = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    INTR   = 3'd6,
    HALT   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_after;
  logic [5:0]       r_opreg;
  logic [5:0]       r_functreg;
  logic             r_irq_pend;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic             w_valid;
  logic             w_is_r;
  logic             w_is_addi;
  logic             w_is_lw;
  logic             w_is_sw;
  logic             w_is_beq;
  logic             w_is_j;
  logic [2:0]       w_rop;
  logic             w_boundary;

  // Legality is judged on the live instruction bits while in DECODE.
  always_comb begin
    w_valid = 1'b0;
    case (opcode)
      6'h00: w_valid = (funct == 6'h24) || (funct == 6'h25) || (funct == 6'h20) ||
                       (funct == 6'h22) || (funct == 6'h2a);
      6'h08, 6'h23, 6'h2b, 6'h04, 6'h02: w_valid = 1'b1;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_is_r    = (r_opreg == 6'h00);
  assign w_is_addi = (r_opreg == 6'h08);
  assign w_is_lw   = (r_opreg == 6'h23);
  assign w_is_sw   = (r_opreg == 6'h2b);
  assign w_is_beq  = (r_opreg == 6'h04);
  assign w_is_j    = (r_opreg == 6'h02);

  always_comb begin
    case (r_functreg)
      6'h24:   w_rop = 3'b000;
      6'h25:   w_rop = 3'b001;
      6'h22:   w_rop = 3'b110;
      6'h2a:   w_rop = 3'b111;
      default: w_rop = 3'b010;
    endcase
  end

  assign w_after = r_irq_pend ? INTR : FETCH;

  // NOTE: every output and w_next gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = 3'b010;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    INT      = 1'b0;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    w_next   = r_state;
    case (r_state)
      VEC: begin
        INT     = 1'b1;
        pcWrite = 1'b1;
        w_next  = FETCH;
      end
      FETCH: begin
        irWrite = 1'b1;
        w_next  = DECODE;
      end
      DECODE: w_next = w_valid ? EXEC : HALT;
      EXEC: begin
        if (w_is_r) begin
          RegDst = 1'b1;
          op     = w_rop;
          w_next = WB;
        end else if (w_is_addi) begin
          ALUSrc = 1'b1;
          w_next = WB;
        end else if (w_is_lw || w_is_sw) begin
          ALUSrc = 1'b1;
          w_next = MEM;
        end else if (w_is_beq) begin
          op      = 3'b110;
          branch  = 1'b1;
          pcWrite = 1'b1;
          w_next  = w_after;
        end else if (w_is_j) begin
          jump    = 1'b1;
          pcWrite = 1'b1;
          w_next  = w_after;
        end else begin
          w_next = HALT;
        end
      end
      MEM: begin
        ALUSrc = 1'b1;
        if (w_is_lw) begin
          MemRead = 1'b1;
          w_next  = WB;
        end else begin
          MemWrite = 1'b1;
          pcWrite  = 1'b1;
          w_next   = w_after;
        end
      end
      WB: begin
        // ALU/memory controls repeat the previous phase so z and memOut hold.
        RegWrite = 1'b1;
        pcWrite  = 1'b1;
        if (w_is_r) begin
          RegDst = 1'b1;
          op     = w_rop;
        end else begin
          ALUSrc  = 1'b1;
          MemRead = w_is_lw;
          Mem2Reg = w_is_lw;
        end
        w_next = w_after;
      end
      INTR: begin
        INT     = 1'b1;
        pcWrite = 1'b1;
        w_next  = FETCH;
      end
      HALT:    w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  assign w_boundary = pcWrite && (r_state != VEC) && (r_state != INTR);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order statements are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= VEC;
      r_opreg    <= '0;
      r_functreg <= '0;
      r_irq_pend <= 1'b0;
      r_illegal  <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_opreg    <= opcode;
        r_functreg <= funct;
        if (!w_valid) r_illegal <= 1'b1;
      end
      if (w_boundary) r_retired <= r_retired + CNT_W'(1);
      // A request arriving on the INTR-entry edge survives the clear.
      if (irq && (r_state != HALT)) r_irq_pend <= 1'b1;
      else if (w_next == INTR)      r_irq_pend <= 1'b0;
    end
  end

  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_ymc_ctrl.sv
// Self-checking bench for ymc_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, checked every cycle.
module tb_ymc_ctrl;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src;
    logic [2:0]       op;
    logic             mem_read;
    logic             mem_write;
    logic             mem2reg;
    logic             branch;
    logic             jump;
    logic             int_e;
    logic             pc_write;
    logic             ir_write;
    logic             illegal;
    logic [CNT_W-1:0] retired;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             irq;
  logic             RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic             branch, jump, INT, pcWrite, irWrite, illegal;
  logic [2:0]       op;
  logic [CNT_W-1:0] retired;

  exp_t exp_q[$];
  exp_t seq[$];
  int   m_retired;
  int   n_checks;
  int   n_errors;

  ymc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .irq(irq),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
    .branch(branch), .jump(jump), .INT(INT), .pcWrite(pcWrite),
    .irWrite(irWrite), .illegal(illegal), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e         = '0;
    e.op      = 3'b010;
    e.retired = CNT_W'(m_retired);
    return e;
  endfunction

  function automatic exp_t vec_out();
    exp_t e;
    e          = blank();
    e.int_e    = 1'b1;
    e.pc_write = 1'b1;
    return e;
  endfunction

  // Expected cycles of one instruction, from FETCH to its final phase.
  task automatic build_seq(input logic [5:0] opc, input logic [5:0] fn);
    exp_t e;
    logic is_r;
    logic [2:0] rop;
    seq.delete();
    e = blank(); e.ir_write = 1'b1; seq.push_back(e);
    e = blank(); seq.push_back(e);
    is_r = (opc == 6'h00) && (fn == 6'h24 || fn == 6'h25 || fn == 6'h20 ||
                              fn == 6'h22 || fn == 6'h2a);
    rop = (fn == 6'h24) ? 3'b000 : (fn == 6'h25) ? 3'b001 :
          (fn == 6'h20) ? 3'b010 : (fn == 6'h22) ? 3'b110 : 3'b111;
    if (is_r) begin
      e = blank(); e.reg_dst = 1'b1; e.op = rop; seq.push_back(e);
      e.reg_write = 1'b1; e.pc_write = 1'b1; seq.push_back(e);
    end else if (opc == 6'h08) begin
      e = blank(); e.alu_src = 1'b1; seq.push_back(e);
      e.reg_write = 1'b1; e.pc_write = 1'b1; seq.push_back(e);
    end else if (opc == 6'h23) begin
      e = blank(); e.alu_src = 1'b1; seq.push_back(e);
      e.mem_read = 1'b1; seq.push_back(e);
      e.mem2reg = 1'b1; e.reg_write = 1'b1; e.pc_write = 1'b1; seq.push_back(e);
    end else if (opc == 6'h2b) begin
      e = blank(); e.alu_src = 1'b1; seq.push_back(e);
      e.mem_write = 1'b1; e.pc_write = 1'b1; seq.push_back(e);
    end else if (opc == 6'h04) begin
      e = blank(); e.op = 3'b110; e.branch = 1'b1; e.pc_write = 1'b1; seq.push_back(e);
    end else if (opc == 6'h02) begin
      e = blank(); e.jump = 1'b1; e.pc_write = 1'b1; seq.push_back(e);
    end
  endtask

  task automatic drive_cycles(input int n, input int irq_from, input int irq_to);
    for (int i = 0; i < n; i++) begin
      irq = (i >= irq_from) && (i <= irq_to);
      @(posedge clk); #1;
    end
    irq = 1'b0;
  endtask

  task automatic do_reset(input int n);
    m_retired = 0;
    rst = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(vec_out());
    drive_cycles(n, -1, -1);
    rst = 1'b0;
    exp_q.push_back(vec_out());
    drive_cycles(1, -1, -1);
  endtask

  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int irq_at);
    exp_t e;
    build_seq(opc, fn);
    if (irq_at >= 0) begin
      e = blank(); e.retired = CNT_W'(m_retired + 1);
      e.int_e = 1'b1; e.pc_write = 1'b1;
      seq.push_back(e);
    end
    foreach (seq[i]) exp_q.push_back(seq[i]);
    opcode = opc;
    funct  = fn;
    drive_cycles(seq.size(), irq_at, irq_at);
    m_retired = (m_retired + 1) % (1 << CNT_W);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_halt(input logic [5:0] opc, input logic [5:0] fn, input int n);
    exp_t e;
    build_seq(opc, fn);
    e = blank(); e.illegal = 1'b1;
    for (int i = 0; i < n; i++) seq.push_back(e);
    foreach (seq[i]) exp_q.push_back(seq[i]);
    opcode = opc;
    funct  = fn;
    drive_cycles(seq.size(), 2, seq.size());
  endtask

  task automatic mid_reset(input logic [5:0] opc, input logic [5:0] fn, input int k);
    build_seq(opc, fn);
    for (int i = 0; i < k; i++) exp_q.push_back(seq[i]);
    opcode = opc;
    funct  = fn;
    drive_cycles(k, -1, -1);
    do_reset(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("outputs@%0t", $time),
            32'({RegDst, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, branch,
                 jump, INT, pcWrite, irWrite, illegal, retired}),
            32'(e));
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_retired = 0;
    rst       = 1'b1;
    irq       = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    @(posedge clk); #1;
    do_reset(3);
    check("reset_retired", 32'(retired), 32'd0);

    build_seq(6'h23, 6'h00);
    check("lw_len", 32'(seq.size()), 32'd5);
    build_seq(6'h04, 6'h00);
    check("beq_len", 32'(seq.size()), 32'd3);

    run_instr(6'h00, 6'h20, -1);
    check("add_retired", 32'(retired), 32'd1);
    run_instr(6'h23, 6'h00, -1);
    run_instr(6'h2b, 6'h00, -1);
    check("lw_sw_retired", 32'(retired), 32'd3);
    run_instr(6'h04, 6'h00, -1);
    run_instr(6'h02, 6'h00, -1);
    run_instr(6'h08, 6'h00, -1);
    run_instr(6'h00, 6'h24, -1);
    run_instr(6'h00, 6'h25, -1);
    run_instr(6'h00, 6'h2a, -1);
    run_instr(6'h00, 6'h22, 2);
    check("irq_retired", 32'(retired), 32'd10);
    run_instr(6'h02, 6'h00, -1);

    run_halt(6'h3f, 6'h00, 20);
    check("halt_illegal", 32'(illegal), 32'd1);
    do_reset(1);
    check("rst_clears_illegal", 32'(illegal), 32'd0);

    run_halt(6'h00, 6'h21, 3);
    do_reset(1);

    mid_reset(6'h2b, 6'h00, 3);

    for (int i = 0; i < 17; i++) run_instr(6'h02, 6'h00, -1);
    check("retired_wrap", 32'(retired), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
